parser_bit_reader: RTL and testbench

Bit-level stream supplier for the OBU header parsers (sequence header, frame header, ...). Accepts a byte stream from the OBU framing stage over a valid/ready handshake. Presents an MSB-first window of `PARSER_DATA_WIDTH` bits to the active parser. Advances that window in response to the parser's `pop` (consume a full window) and `pad`/`pad_len` (consume a partial window) controls.

---
 rtl/parser_pkg.sv | 15 +
 rtl/parser_bit_reader.sv | 129 ++++++++++++
 tb/tb_parser_bit_reader.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parser_pkg.sv
// ---------------------------------------------------------------------------
// parser_pkg
// Shared definitions for the OBU header parsers and their bit reader.
//   PARSER_DATA_WIDTH : width of the bit window handed to every header parser
//   PAD_LEN_W         : width of a partial-consume amount (0..PARSER_DATA_WIDTH-1)
//   pad_len_t         : type of the partial-consume amount
// ---------------------------------------------------------------------------
package parser_pkg;

  localparam int PARSER_DATA_WIDTH = 32;
  localparam int PAD_LEN_W         = $clog2(PARSER_DATA_WIDTH);

  typedef logic [PAD_LEN_W-1:0] pad_len_t;

endpackage

// File: rtl/parser_bit_reader.sv
// ---------------------------------------------------------------------------
// parser_bit_reader
// Bit-level stream supplier for the OBU header parsers. Bytes arrive from the
// OBU framing stage over valid/ready and are packed MSB-first into a bit
// buffer. The active parser sees the oldest PARSER_DATA_WIDTH bits and
// consumes a full window (pop) or a partial window (pad/pad_len).
//
// Ports:
//   i_clk          : clock, everything on the rising edge
//   i_rst          : synchronous active-high reset
//   i_in_data      : upstream word, MSB is the first bit in stream order
//   i_in_valid     : i_in_data is valid
//   o_in_ready     : the word is accepted this cycle when valid
//   i_flush        : drop all buffered bits, counters and error (OBU boundary)
//   o_data_out     : next unread bits, MSB is the oldest bit
//   o_data_valid   : o_data_out holds PARSER_DATA_WIDTH real bits
//   i_pop          : consume PARSER_DATA_WIDTH bits
//   i_pad          : consume i_pad_len bits
//   i_pad_len      : partial consume amount
//   o_bit_count    : bits consumed since reset/flush, wraps modulo 2^32
//   o_byte_aligned : o_bit_count is a multiple of 8
//   o_err          : sticky protocol-violation flag
// ---------------------------------------------------------------------------
module parser_bit_reader
  import parser_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int BUF_WIDTH = 2 * PARSER_DATA_WIDTH
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [IN_WIDTH-1:0]          i_in_data,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic                         i_flush,
  output logic [PARSER_DATA_WIDTH-1:0] o_data_out,
  output logic                         o_data_valid,
  input  logic                         i_pop,
  input  logic                         i_pad,
  input  pad_len_t                     i_pad_len,
  output logic [31:0]                  o_bit_count,
  output logic                         o_byte_aligned,
  output logic                         o_err
);

  localparam int OCC_W = $clog2(BUF_WIDTH + 1);
  // One extra bit so occupancy sums and differences never wrap.
  localparam int SUM_W = OCC_W + 1;

  logic [BUF_WIDTH-1:0]  r_buf;
  logic [OCC_W-1:0]      r_occ;
  logic [31:0]           r_bit_count;
  logic                  r_err;

  logic [SUM_W-1:0]      w_occ_ext;
  logic                  w_data_valid;
  logic                  w_in_ready;
  logic                  w_fire;
  logic [SUM_W-1:0]      w_consumed;
  logic                  w_proto_err;
  logic [SUM_W-1:0]      w_remain;
  logic [OCC_W-1:0]      w_next_occ;
  logic [BUF_WIDTH-1:0]  w_shifted;
  logic [BUF_WIDTH-1:0]  w_insert;
  logic [BUF_WIDTH-1:0]  w_next_buf;

  assign w_occ_ext    = {1'b0, r_occ};
  assign w_data_valid = (w_occ_ext >= SUM_W'(PARSER_DATA_WIDTH));

  // Readiness looks only at the registered occupancy, so a full buffer stays
  // not-ready during the cycle of a pop and recovers on the following cycle.
  assign w_in_ready = !i_rst && !i_flush &&
                      ((w_occ_ext + SUM_W'(IN_WIDTH)) <= SUM_W'(BUF_WIDTH));
  assign w_fire     = i_in_valid && w_in_ready;

  // Consume arbitration: consuming with no full window is refused outright;
  // pop and pad together keeps the pad and flags the dropped pop.
  always_comb begin
    w_consumed  = '0;
    w_proto_err = 1'b0;
    if ((i_pop || i_pad) && !w_data_valid) begin
      w_proto_err = 1'b1;
    end else if (i_pop && i_pad) begin
      w_consumed  = SUM_W'(i_pad_len);
      w_proto_err = 1'b1;
    end else if (i_pop) begin
      w_consumed  = SUM_W'(PARSER_DATA_WIDTH);
    end else if (i_pad) begin
      w_consumed  = SUM_W'(i_pad_len);
    end
  end

  // Any accepted consume is at most PARSER_DATA_WIDTH and only happens with a
  // full window, so w_remain can never go negative.
  assign w_remain   = w_occ_ext - w_consumed;
  assign w_next_occ = OCC_W'(w_remain + (w_fire ? SUM_W'(IN_WIDTH) : SUM_W'(0)));

  // Bits below the valid region are kept at zero (reset and flush clear the
  // buffer, and the left shift fills with zeros), so the new word can simply
  // be OR-ed in right behind the last remaining valid bit.
  assign w_shifted  = r_buf << w_consumed;
  assign w_insert   = {i_in_data, {(BUF_WIDTH-IN_WIDTH){1'b0}}} >> w_remain;
  assign w_next_buf = w_fire ? (w_shifted | w_insert) : w_shifted;

  // State update; reset and flush both return the reader to an empty stream.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_buf       <= '0;
      r_occ       <= '0;
      r_bit_count <= '0;
      r_err       <= 1'b0;
    end else begin
      r_buf       <= w_next_buf;
      r_occ       <= w_next_occ;
      r_bit_count <= r_bit_count + 32'(w_consumed);
      if (w_proto_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_in_ready     = w_in_ready;
  assign o_data_valid   = w_data_valid;
  assign o_data_out     = r_buf[BUF_WIDTH-1 -: PARSER_DATA_WIDTH];
  assign o_bit_count    = r_bit_count;
  assign o_byte_aligned = (r_bit_count[2:0] == 3'd0);
  assign o_err          = r_err;

endmodule

// File: tb/tb_parser_bit_reader.sv
// ---------------------------------------------------------------------------
// tb_parser_bit_reader
// Self-checking bench for parser_bit_reader. The reference model keeps the
// unread stream as a queue of bits: accepted bytes are pushed MSB-first,
// consumes pop bits off the front, and the expected window is simply the
// first 32 entries of that queue.
// ---------------------------------------------------------------------------
module tb_parser_bit_reader;
  import parser_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] data_out;
  logic        data_valid;
  logic        pop;
  logic        pad;
  pad_len_t    pad_len;
  logic [31:0] bit_count;
  logic        byte_aligned;
  logic        err;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit          mq[$];
  logic [31:0] mbc;
  logic        merr;

  parser_bit_reader #(.IN_WIDTH(8), .BUF_WIDTH(64)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_in_data      (in_data),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_flush        (flush),
    .o_data_out     (data_out),
    .o_data_valid   (data_valid),
    .i_pop          (pop),
    .i_pad          (pad),
    .i_pad_len      (pad_len),
    .o_bit_count    (bit_count),
    .o_byte_aligned (byte_aligned),
    .o_err          (err)
  );

  always #5 clk = ~clk;

  // Expected outputs derived from the bit queue and the currently driven inputs.
  function automatic logic [31:0] exp_window();
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) begin
      w = {w[30:0], (i < mq.size()) ? logic'(mq[i]) : 1'b0};
    end
    return w;
  endfunction

  function automatic logic exp_valid();
    return mq.size() >= 32;
  endfunction

  function automatic logic exp_ready();
    return !rst && !flush && (mq.size() + 8 <= 64);
  endfunction

  // Advance the reference model by one clock using the pre-edge state.
  task automatic model_step(input logic v, input logic [7:0] d, input logic po,
                            input logic pa, input logic [4:0] pl,
                            input logic fl, input logic r);
    int  cons;
    bit  fire;
    bit  dv;
    if (r || fl) begin
      mq.delete();
      mbc  = '0;
      merr = 1'b0;
    end else begin
      dv   = (mq.size() >= 32);
      fire = v && (mq.size() + 8 <= 64);
      cons = 0;
      if ((po || pa) && !dv) merr = 1'b1;
      else if (po && pa) begin cons = int'(pl); merr = 1'b1; end
      else if (po) cons = 32;
      else if (pa) cons = int'(pl);
      for (int i = 0; i < cons; i++) void'(mq.pop_front());
      if (fire) for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
      mbc = mbc + 32'(cons);
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, settle past the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic po,
                       input logic pa, input logic [4:0] pl,
                       input logic fl, input logic r);
    in_valid = v; in_data = d; pop = po; pad = pa; pad_len = pl;
    flush = fl; rst = r;
    @(posedge clk);
    model_step(v, d, po, pa, pl, fl, r);
    #1;
  endtask

  task automatic feed(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_flush();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_data_valid got=%b exp=0", data_valid); end
    total++; if (data_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_data_out got=%h exp=0", data_out); end
    total++; if (bit_count !== 32'h0) begin bad++; $display("[TB] FAIL reset_bit_count got=%0d exp=0", bit_count); end
    total++; if (byte_aligned !== 1'b1) begin bad++; $display("[TB] FAIL reset_byte_aligned got=%b exp=1", byte_aligned); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
    idle();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_fill_window();
    logic [7:0] bytes [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_flush();
    for (int i = 0; i < 4; i++) begin
      feed(bytes[i]);
      if (i == 2) begin
        total++; if (data_valid !== 1'b0) begin bad++; $display("[TB] FAIL fill_partial_valid got=%b exp=0", data_valid); end
      end
    end
    total++; if (data_valid !== 1'b1) begin bad++; $display("[TB] FAIL fill_valid got=%b exp=1", data_valid); end
    total++; if (data_out !== 32'h12345678) begin bad++; $display("[TB] FAIL fill_data_out got=%h exp=12345678", data_out); end
    total++; if (in_ready !== exp_ready()) begin bad++; $display("[TB] FAIL fill_in_ready got=%b exp=%b", in_ready, exp_ready()); end
  endtask

  task automatic test_pad();
    logic [7:0] bytes [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    do_flush();
    for (int i = 0; i < 5; i++) feed(bytes[i]);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    total++; if (data_out !== 32'h91A2B3C4) begin bad++; $display("[TB] FAIL pad_data_out got=%h exp=91a2b3c4", data_out); end
    total++; if (bit_count !== 32'd3) begin bad++; $display("[TB] FAIL pad_bit_count got=%0d exp=3", bit_count); end
    total++; if (byte_aligned !== 1'b0) begin bad++; $display("[TB] FAIL pad_byte_aligned got=%b exp=0", byte_aligned); end
    total++; if (data_valid !== 1'b1) begin bad++; $display("[TB] FAIL pad_valid got=%b exp=1", data_valid); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    total++; if (data_out !== exp_window()) begin bad++; $display("[TB] FAIL pad_zero_noop got=%h exp=%h", data_out, exp_window()); end
  endtask

  task automatic test_full();
    logic [7:0] bytes [8];
    do_flush();
    for (int i = 0; i < 8; i++) begin
      bytes[i] = 8'($urandom);
      feed(bytes[i]);
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_in_ready got=%b exp=0", in_ready); end
    // Pop with a byte offered: the byte must not be taken this cycle.
    cycle(1'b1, 8'hEE, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL full_recover_ready got=%b exp=1", in_ready); end
    total++; if (data_out !== {bytes[4], bytes[5], bytes[6], bytes[7]}) begin
      bad++; $display("[TB] FAIL full_after_pop got=%h exp=%h", data_out, {bytes[4], bytes[5], bytes[6], bytes[7]});
    end
    total++; if (bit_count !== 32'd32) begin bad++; $display("[TB] FAIL full_bit_count got=%0d exp=32", bit_count); end
  endtask

  task automatic test_pop_pad_conflict();
    do_flush();
    for (int i = 0; i < 5; i++) feed(8'($urandom));
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    total++; if (bit_count !== 32'd5) begin bad++; $display("[TB] FAIL conflict_bit_count got=%0d exp=5", bit_count); end
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL conflict_err got=%b exp=1", err); end
    total++; if (data_out !== exp_window()) begin bad++; $display("[TB] FAIL conflict_data_out got=%h exp=%h", data_out, exp_window()); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    idle();
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL conflict_err_sticky got=%b exp=1", err); end
    total++; if (bit_count !== 32'd37) begin bad++; $display("[TB] FAIL conflict_pop_after got=%0d exp=37", bit_count); end
    do_flush();
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL conflict_err_flush got=%b exp=0", err); end
  endtask

  task automatic test_pop_empty();
    logic [7:0] bytes [4];
    do_flush();
    for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
    feed(bytes[0]);
    feed(bytes[1]);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL empty_pop_err got=%b exp=1", err); end
    total++; if (bit_count !== 32'd0) begin bad++; $display("[TB] FAIL empty_pop_count got=%0d exp=0", bit_count); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    feed(bytes[2]);
    feed(bytes[3]);
    total++; if (data_valid !== 1'b1) begin bad++; $display("[TB] FAIL empty_pop_valid got=%b exp=1", data_valid); end
    total++; if (data_out !== {bytes[0], bytes[1], bytes[2], bytes[3]}) begin
      bad++; $display("[TB] FAIL empty_pop_data got=%h exp=%h", data_out, {bytes[0], bytes[1], bytes[2], bytes[3]});
    end
  endtask

  task automatic test_flush_midstream(input logic use_rst);
    logic [7:0] bytes [4];
    int guard;
    do_flush();
    // Illegal pop on an empty buffer sets err without consuming anything.
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    guard = 0;
    while (!(mbc == 32'd96 && mq.size() == 40) && guard < 60) begin
      cycle(1'b1, 8'($urandom), (mq.size() >= 32) && (mbc < 96), 1'b0, 5'd0, 1'b0, 1'b0);
      guard++;
    end
    total++; if (bit_count !== 32'd96 || err !== 1'b1) begin
      bad++; $display("[TB] FAIL midstream_setup bit_count=%0d err=%b exp 96/1", bit_count, err);
    end
    total++; if (data_valid !== 1'b1 || data_out !== exp_window()) begin
      bad++; $display("[TB] FAIL midstream_window got=%h exp=%h", data_out, exp_window());
    end
    cycle(1'b1, 8'hA5, 1'b1, 1'b0, 5'd0, !use_rst, use_rst);
    total++; if (data_valid !== 1'b0) begin bad++; $display("[TB] FAIL clear_valid rst=%b got=%b exp=0", use_rst, data_valid); end
    total++; if (bit_count !== 32'd0) begin bad++; $display("[TB] FAIL clear_bit_count rst=%b got=%0d exp=0", use_rst, bit_count); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL clear_err rst=%b got=%b exp=0", use_rst, err); end
    for (int i = 0; i < 4; i++) begin
      bytes[i] = 8'($urandom);
      feed(bytes[i]);
    end
    total++; if (data_out !== {bytes[0], bytes[1], bytes[2], bytes[3]} || data_valid !== 1'b1) begin
      bad++; $display("[TB] FAIL clear_realign rst=%b got=%h exp=%h", use_rst, data_out, {bytes[0], bytes[1], bytes[2], bytes[3]});
    end
  endtask

  task automatic test_random();
    logic        v, po, pa, fl;
    logic [4:0]  pl;
    int          r;
    do_flush();
    for (int n = 0; n < 800; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 19);
      po = 1'b0; pa = 1'b0;
      pl = 5'($urandom);
      if (r == 19) begin
        po = 1'b1; pa = 1'b1;
      end else if (exp_valid() && r < 6) begin
        po = 1'b1;
      end else if (exp_valid() && r < 12) begin
        pa = 1'b1;
      end
      fl = ($urandom_range(0, 99) == 0);
      cycle(v, 8'($urandom), po, pa, pl, fl, 1'b0);
      total++;
      if (in_ready !== exp_ready() || data_valid !== exp_valid() || bit_count !== mbc ||
          byte_aligned !== (mbc[2:0] == 3'd0) || err !== merr ||
          (exp_valid() && data_out !== exp_window())) begin
        bad++;
        $display("[TB] FAIL random_cycle%0d got rdy=%b dv=%b do=%h bc=%0d ba=%b err=%b exp rdy=%b dv=%b do=%h bc=%0d err=%b",
                 n, in_ready, data_valid, data_out, bit_count, byte_aligned, err,
                 exp_ready(), exp_valid(), exp_window(), mbc, merr);
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    pop = 1'b0; pad = 1'b0; pad_len = '0;
    mbc = '0; merr = 1'b0;
    test_reset();
    test_fill_window();
    test_pad();
    test_full();
    test_pop_pad_conflict();
    test_pop_empty();
    test_flush_midstream(1'b0);
    test_flush_midstream(1'b1);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
